// File: rtl/iocfg_ctrl.sv
// iocfg_ctrl: serial configuration sequencer for a daisy-chained IO block ring
// Ports:
//   IOCLK      clock, all state on rising edge
//   RSTN       asynchronous active-low reset
//   START      begin a configuration pass (sampled in IDLE only)
//   ABORT      cancel a pass in LOAD/SHIFT; no latch is issued
//   WDATA      configuration word for the current block
//   WVALID     WDATA valid
//   WREADY     word accepted this cycle (LOAD and no ABORT)
//   CFG_SEN    chain shift enable
//   CFG_SDO    serial data to chain, MSB first
//   CFG_LATCH  one-cycle strobe copying shift regs to active config
//   BUSY       high in every state except IDLE
//   DONE       one-cycle pulse after a successful latch
//   IDX        index of the word being loaded/shifted
module iocfg_ctrl #(
    parameter int NUM_IOB = 8,
    parameter int CFG_W   = 3,
    parameter int IDX_W   = (NUM_IOB > 1) ? $clog2(NUM_IOB) : 1
) (
    input  logic             IOCLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CFG_W-1:0] WDATA,
    input  logic             WVALID,
    output logic             WREADY,
    output logic             CFG_SEN,
    output logic             CFG_SDO,
    output logic             CFG_LATCH,
    output logic             BUSY,
    output logic             DONE,
    output logic [IDX_W-1:0] IDX
);
    localparam int CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, FIN} state_t;

    state_t           st, nxt;
    logic [CFG_W-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             last_bit, last_blk;

    assign last_bit = cnt == CNT_W'(CFG_W - 1);
    assign last_blk = IDX == IDX_W'(NUM_IOB - 1);

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = (START && !ABORT) ? LOAD : IDLE;
            LOAD:    nxt = ABORT ? IDLE : WVALID ? SHIFT : LOAD;
            SHIFT:   nxt = ABORT ? IDLE : !last_bit ? SHIFT : last_blk ? LATCH : LOAD;
            LATCH:   nxt = FIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge IOCLK or negedge RSTN) begin
        if (!RSTN) begin
            st  <= IDLE;
            sr  <= '0;
            cnt <= '0;
            IDX <= '0;
        end else begin
            st <= nxt;
            if (WREADY && WVALID) begin
                sr  <= WDATA;
                cnt <= '0;
            end else if (st == SHIFT) begin
                sr  <= sr << 1;
                cnt <= cnt + 1'b1;
            end
            // any return to IDLE (finish or abort) rewinds the index so the next pass starts at 0
            if (nxt == IDLE)
                IDX <= '0;
            else if (st == SHIFT && nxt == LOAD)
                IDX <= IDX + 1'b1;
        end
    end

    // outputs decode from state only; ABORT gates WREADY so an aborted word is never taken
    assign WREADY    = (st == LOAD) && !ABORT;
    assign CFG_SEN   = st == SHIFT;
    assign CFG_SDO   = CFG_SEN && sr[CFG_W-1];
    assign CFG_LATCH = st == LATCH;
    assign DONE      = st == FIN;
    assign BUSY      = st != IDLE;
endmodule
